// File: rtl/factorial_engine_if.sv
// Handshake bundle for factorial_engine: start/number request, busy/done
// status and the registered fact/overflow result.
interface factorial_engine_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32
);
   logic             start;
   logic [IN_W-1:0]  number;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] fact;
   logic             overflow;

   // requester side
   modport master (output start, number, input busy, done, fact, overflow);
   // engine side
   modport slave  (input start, number, output busy, done, fact, overflow);
endinterface

// File: rtl/factorial_engine.sv
// Iterative factorial unit: one multiply per clock using an accumulator and a
// down-counter, with a start/done handshake and sticky overflow detection.
// Optional build macro FACT_SATURATE_EN: an overflowed result is reported as
// all ones instead of the value truncated modulo 2^OUT_W.
module factorial_engine #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   factorial_engine_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic [OUT_W-1:0]    acc;
   logic [IN_W-1:0]     cnt;
   logic                ovf_int;
   logic [OUT_W-1:0]    fact_q;
   logic                ovf_q;
   logic [OUT_W+IN_W-1:0] prod;
   logic [OUT_W-1:0]    fact_next;

   // full-width product so the bits above OUT_W can flag overflow
   always_comb begin
      prod = {{IN_W{1'b0}}, acc} * {{OUT_W{1'b0}}, cnt};
   end

   // value latched into fact on completion
   always_comb begin
`ifdef FACT_SATURATE_EN
      fact_next = ovf_int ? {OUT_W{1'b1}} : acc;
`else
      fact_next = acc;
`endif
   end

   // control FSM plus datapath; fact/overflow only move on MUL->DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         acc     <= OUT_W'(1);
         cnt     <= '0;
         ovf_int <= 1'b0;
         fact_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  acc     <= OUT_W'(1);
                  cnt     <= bus.number;
                  ovf_int <= 1'b0;
                  state   <= S_MUL;
               end
            end
            S_MUL: begin
               if (cnt > IN_W'(1)) begin
                  // after a wrap the truncated acc keeps the chain going
                  acc     <= prod[OUT_W-1:0];
                  cnt     <= cnt - IN_W'(1);
                  ovf_int <= ovf_int | (|prod[OUT_W+IN_W-1:OUT_W]);
               end else begin
                  fact_q <= fact_next;
                  ovf_q  <= ovf_int;
                  state  <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = (state != S_IDLE);
   assign bus.done     = (state == S_DONE);
   assign bus.fact     = fact_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: a default-width instance (8/32) driven
// from a vector table plus corner sequences, and a narrow 4/8 instance.
module tb_factorial_engine;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   factorial_engine_if #(.IN_W(8), .OUT_W(32)) ba ();
   factorial_engine_if #(.IN_W(4), .OUT_W(8))  bb ();

   factorial_engine #(.IN_W(8), .OUT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ba));
   factorial_engine #(.IN_W(4), .OUT_W(8))  dut_b (.clk(clk), .reset(reset), .bus(bb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  n;
      logic [31:0] f;
      logic        o;
      int          lat;
   } vec_t;

   vec_t vecs[8];

`ifdef FACT_SATURATE_EN
   localparam logic [31:0] F13 = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] F13 = 32'd1932053504;
`endif

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // one complete job on instance A (b=0) or B (b=1), sampled on negedges
   task automatic run_job(input bit b, input logic [7:0] n, input logic [31:0] ef,
                          input logic eo, input int elat, input string nm);
      int    edges;
      logic  d;
      @(negedge clk);
      if (b) begin bb.start = 1'b1; bb.number = n[3:0]; end
      else   begin ba.start = 1'b1; ba.number = n;      end
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      ba.start = 1'b0;
      bb.start = 1'b0;
      d = b ? bb.done : ba.done;
      while (!d && edges < 300) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         d = b ? bb.done : ba.done;
      end
      check({nm, " latency"}, edges, elat);
      check({nm, " fact"}, b ? {24'd0, bb.fact} : ba.fact, ef);
      check({nm, " overflow"}, {31'd0, b ? bb.overflow : ba.overflow}, {31'd0, eo});
      @(negedge clk);
      check({nm, " done after"}, {31'd0, b ? bb.done : ba.done}, 32'd0);
      check({nm, " busy after"}, {31'd0, b ? bb.busy : ba.busy}, 32'd0);
   endtask

   initial begin
      int pulses;
      logic [31:0] got_f;
      logic        got_o;

      vecs[0] = '{n: 8'd5,  f: 32'd120,       o: 1'b0, lat: 6};
      vecs[1] = '{n: 8'd0,  f: 32'd1,         o: 1'b0, lat: 2};
      vecs[2] = '{n: 8'd1,  f: 32'd1,         o: 1'b0, lat: 2};
      vecs[3] = '{n: 8'd12, f: 32'd479001600, o: 1'b0, lat: 13};
      vecs[4] = '{n: 8'd13, f: F13,           o: 1'b1, lat: 14};
      vecs[5] = '{n: 8'd4,  f: 32'd24,        o: 1'b0, lat: 5};
      vecs[6] = '{n: 8'd2,  f: 32'd2,         o: 1'b0, lat: 3};
      vecs[7] = '{n: 8'd3,  f: 32'd6,         o: 1'b0, lat: 4};

      ba.start = 1'b0; ba.number = '0;
      bb.start = 1'b0; bb.number = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, ba.busy}, 32'd0);
      check("reset done", {31'd0, ba.done}, 32'd0);
      check("reset fact", ba.fact, 32'd0);
      check("reset overflow", {31'd0, ba.overflow}, 32'd0);
      check("reset fact b", {24'd0, bb.fact}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run_job(1'b0, vecs[i].n, vecs[i].f, vecs[i].o, vecs[i].lat, $sformatf("vec%0d", i));

      // start while busy must be ignored: one done, 8! result
      @(negedge clk);
      ba.start = 1'b1; ba.number = 8'd8;
      @(negedge clk);
      ba.start = 1'b0;
      repeat (3) @(negedge clk);
      ba.start = 1'b1; ba.number = 8'd3;
      @(negedge clk);
      ba.start = 1'b0; ba.number = 8'd0;
      pulses = 0; got_f = '0; got_o = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (ba.done) begin
            pulses++;
            got_f = ba.fact;
            got_o = ba.overflow;
         end
         @(negedge clk);
      end
      check("busy-start pulses", pulses, 32'd1);
      check("busy-start fact", got_f, 32'd40320);
      check("busy-start overflow", {31'd0, got_o}, 32'd0);

      // async reset during the 4th MUL cycle aborts the job
      @(negedge clk);
      ba.start = 1'b1; ba.number = 8'd10;
      @(posedge clk);
      @(negedge clk);
      ba.start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid-job busy before reset", {31'd0, ba.busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort busy", {31'd0, ba.busy}, 32'd0);
      check("abort done", {31'd0, ba.done}, 32'd0);
      check("abort fact", ba.fact, 32'd0);
      check("abort overflow", {31'd0, ba.overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_job(1'b0, 8'd4, 32'd24, 1'b0, 5, "post-abort n=4");

      // narrow instance: wrap modulo 256, overflow cleared per job
      run_job(1'b1, 8'd6, 32'hD0, 1'b1, 7, "narrow n=6");
      run_job(1'b1, 8'd5, 32'd120, 1'b0, 6, "narrow n=5");
      run_job(1'b1, 8'd0, 32'd1, 1'b0, 2, "narrow n=0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
